// File: rtl/vga_timing_recovery.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_recovery                                                      |
// | Measures an incoming VGA sync stream, locks onto it, regenerates x/y.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_timing_recovery #(
  parameter int unsigned LOCK_FRAMES       = 2,
  parameter bit          HSYNC_ACTIVE_HIGH = 1'b1,
  parameter bit          VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [9:0]  x_coord,
  output logic [9:0]  y_coord,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [9:0]  v_total,
  output logic        err
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_hs_prev, r_vs_prev, r_de_prev;
  logic [10:0] r_h_cnt;
  logic        r_hp_valid;
  logic [10:0] r_line_ref;
  logic        r_mism;
  logic [9:0]  r_v_cnt;
  logic        r_ovf;
  logic [10:0] r_cand_h;
  logic [9:0]  r_cand_v;
  logic [3:0]  r_good;
  logic        r_first_line;

  logic        w_hs_act, w_vs_act, w_hs_rise, w_vs_rise, w_de_rise;
  logic [10:0] w_period;
  logic        w_p_valid, w_timeout, w_frame_ok, w_pair_eq_cand, w_pair_eq_tot;
  logic [3:0]  w_good_inc;
  logic        w_lock_hit, w_stay_locked, w_hs_err, w_first_eff;

  assign w_hs_act       = HSYNC_ACTIVE_HIGH ? hsync_in : ~hsync_in;
  assign w_vs_act       = VSYNC_ACTIVE_HIGH ? vsync_in : ~vsync_in;
  assign w_hs_rise      = pix_en & w_hs_act & ~r_hs_prev;
  assign w_vs_rise      = pix_en & w_vs_act & ~r_vs_prev;
  assign w_de_rise      = de_in & ~r_de_prev;
  assign w_period       = r_h_cnt + 11'd1;
  assign w_p_valid      = w_hs_rise & r_hp_valid;
  assign w_timeout      = pix_en & ~w_hs_rise & (r_h_cnt == 11'h7FF);
  assign w_frame_ok     = ~r_mism & (r_line_ref != 11'd0) & (r_v_cnt != 10'd0) & ~r_ovf;
  assign w_pair_eq_cand = (r_line_ref == r_cand_h) & (r_v_cnt == r_cand_v);
  assign w_pair_eq_tot  = (r_line_ref == h_total) & (r_v_cnt == v_total);
  assign w_good_inc     = r_good + 4'd1;
  assign w_lock_hit     = (w_good_inc >= 4'(LOCK_FRAMES));
  // A line-period check only applies if the frame check on this same sample kept lock
  assign w_stay_locked  = (r_state == LOCKED) & (~w_vs_rise | (w_frame_ok & w_pair_eq_tot));
  assign w_hs_err       = w_stay_locked & w_p_valid & (w_period != h_total);
  assign w_first_eff    = r_first_line | w_vs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SEARCH;
      r_hs_prev    <= 1'b1;
      r_vs_prev    <= 1'b1;
      r_de_prev    <= 1'b0;
      r_h_cnt      <= 11'd0;
      r_hp_valid   <= 1'b0;
      r_line_ref   <= 11'd0;
      r_mism       <= 1'b0;
      r_v_cnt      <= 10'd0;
      r_ovf        <= 1'b0;
      r_cand_h     <= 11'd0;
      r_cand_v     <= 10'd0;
      r_good       <= 4'd0;
      r_first_line <= 1'b0;
      x_coord      <= 10'd0;
      y_coord      <= 10'd0;
      pixel_valid  <= 1'b0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      h_total      <= 11'd0;
      v_total      <= 10'd0;
      err          <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      err         <= 1'b0;
      if (pix_en) begin
        r_hs_prev   <= w_hs_act;
        r_vs_prev   <= w_vs_act;
        r_de_prev   <= de_in;
        frame_start <= w_vs_rise;
        pixel_valid <= locked & de_in;

        // Coordinate regeneration runs regardless of lock state
        if (w_vs_rise) r_first_line <= 1'b1;
        if (de_in) begin
          if (w_de_rise) begin
            x_coord <= 10'd0;
            if (w_first_eff) begin
              y_coord      <= 10'd0;
              r_first_line <= 1'b0;
            end else begin
              y_coord <= y_coord + 10'd1;
            end
          end else if (x_coord != 10'h3FF) begin
            x_coord <= x_coord + 10'd1;
          end
        end

        if (w_timeout) begin
          r_state    <= SEARCH;
          locked     <= 1'b0;
          err        <= locked;
          r_hp_valid <= 1'b0;
          r_line_ref <= 11'd0;
          r_mism     <= 1'b0;
          r_v_cnt    <= 10'd0;
          r_ovf      <= 1'b0;
          r_cand_h   <= 11'd0;
          r_cand_v   <= 10'd0;
          r_good     <= 4'd0;
        end else begin
          r_h_cnt <= w_hs_rise ? 11'd0 : r_h_cnt + 11'd1;
          if (w_hs_rise) r_hp_valid <= 1'b1;

          // The frame closes first; a coincident hsync edge is line 1 of the next frame
          if (w_vs_rise) begin
            r_mism     <= 1'b0;
            r_ovf      <= 1'b0;
            r_v_cnt    <= w_hs_rise ? 10'd1 : 10'd0;
            r_line_ref <= w_p_valid ? w_period : 11'd0;
          end else if (w_hs_rise) begin
            if (r_v_cnt == 10'h3FF) r_ovf <= 1'b1;
            else                    r_v_cnt <= r_v_cnt + 10'd1;
            if (w_p_valid) begin
              if (r_line_ref == 11'd0)        r_line_ref <= w_period;
              else if (w_period != r_line_ref) r_mism     <= 1'b1;
            end
          end

          if (w_vs_rise) begin
            case (r_state)
              SEARCH: r_state <= ACQUIRE;
              ACQUIRE: begin
                if (w_frame_ok) begin
                  r_cand_h <= r_line_ref;
                  r_cand_v <= r_v_cnt;
                  r_good   <= 4'd1;
                  if (LOCK_FRAMES == 1) begin
                    r_state <= LOCKED;
                    locked  <= 1'b1;
                    h_total <= r_line_ref;
                    v_total <= r_v_cnt;
                  end else begin
                    r_state <= VERIFY;
                  end
                end
              end
              VERIFY: begin
                if (!w_frame_ok) begin
                  r_state <= ACQUIRE;
                end else if (w_pair_eq_cand) begin
                  r_good <= w_good_inc;
                  if (w_lock_hit) begin
                    r_state <= LOCKED;
                    locked  <= 1'b1;
                    h_total <= r_line_ref;
                    v_total <= r_v_cnt;
                  end
                end else begin
                  r_cand_h <= r_line_ref;
                  r_cand_v <= r_v_cnt;
                  r_good   <= 4'd1;
                end
              end
              LOCKED: begin
                if (!(w_frame_ok && w_pair_eq_tot)) begin
                  err    <= 1'b1;
                  locked <= 1'b0;
                  if (w_frame_ok) begin
                    r_state  <= VERIFY;
                    r_cand_h <= r_line_ref;
                    r_cand_v <= r_v_cnt;
                    r_good   <= 4'd1;
                  end else begin
                    r_state <= ACQUIRE;
                  end
                end
              end
              default: r_state <= SEARCH;
            endcase
          end

          if (w_hs_err) begin
            err     <= 1'b1;
            locked  <= 1'b0;
            r_state <= ACQUIRE;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
